// File: rtl/reg_scoreboard_pkg.sv
// Shared sizes and types for the register scoreboard.
// Hazard causes are exported for debug visibility.
package reg_scoreboard_pkg;
  localparam int REG_COUNT = 32;
  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    HZ_NONE,
    HZ_RAW,
    HZ_WAW,
    HZ_CAP
  } hazard_e;

  typedef struct packed {
    logic                 vld;
    logic [REG_IDX_W-1:0] rd;
  } wb_stage_t;
endpackage

// File: rtl/reg_scoreboard_wb_pipe_tracker.sv
// Fixed-depth {valid, rd} writeback shadow of the short pipe.
// Reports which registers have a short write still in flight.
module wb_pipe_tracker
  import reg_scoreboard_pkg::*;
#(
  parameter int WB_LAT = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_flush,
  input  logic                 i_push,
  input  logic [REG_IDX_W-1:0] i_push_rd,
  output logic [REG_COUNT-1:0] o_occ
);

  wb_stage_t r_pipe [WB_LAT];

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      for (int i = 0; i < WB_LAT; i++)
        r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= {i_push, i_push_rd};
      for (int i = 1; i < WB_LAT; i++)
        r_pipe[i] <= r_pipe[i-1];
    end
  end

  // Last stage still counts: its write lands on the coming edge.
  always_comb begin
    o_occ = '0;
    for (int i = 0; i < WB_LAT; i++)
      if (r_pipe[i].vld)
        o_occ[r_pipe[i].rd] = 1'b1;
    o_occ[0] = 1'b0;
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Issue-side RAW/WAW/atomic-cap hazard controller for the
// 32-entry register file with pipe and atomic write ports.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int WB_LAT          = 3,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  input  logic [REG_IDX_W-1:0] issue_rs1,
  input  logic [REG_IDX_W-1:0] issue_rs2,
  input  logic                 issue_use_rs1,
  input  logic                 issue_use_rs2,
  input  logic [REG_IDX_W-1:0] issue_rd,
  input  logic                 issue_long,
  output logic                 issue_ready,
  input  logic                 atomic_done_valid,
  input  logic [REG_IDX_W-1:0] atomic_done_rd,
  input  logic                 flush,
  output logic [REG_COUNT-1:0] busy_mask,
  output logic [3:0]           outstanding,
  output logic                 sb_error
);

  logic [REG_COUNT-1:0] r_pending;
  logic [3:0]           r_outstanding;
  logic                 r_err;

  logic [REG_COUNT-1:0] w_occ;
  logic [REG_COUNT-1:0] w_busy;
  logic                 w_raw;
  logic                 w_waw;
  logic                 w_cap;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_set;
  logic                 w_done_ok;
  hazard_e              w_cause;

  wb_pipe_tracker #(
    .WB_LAT (WB_LAT)
  ) u_pipe (
    .clk       (clk),
    .reset     (reset),
    .i_flush   (flush),
    .i_push    (w_push),
    .i_push_rd (issue_rd),
    .o_occ     (w_occ)
  );

  assign w_busy = (r_pending | w_occ) & ~REG_COUNT'(1);

  assign w_raw = (issue_use_rs1 && issue_rs1 != '0 && w_busy[issue_rs1])
              || (issue_use_rs2 && issue_rs2 != '0 && w_busy[issue_rs2]);
  assign w_waw = issue_rd != '0 && w_busy[issue_rd];
  assign w_cap = issue_long && r_outstanding == 4'(MAX_OUTSTANDING);

  always_comb begin
    w_cause = HZ_NONE;
    priority case (1'b1)
      w_raw:   w_cause = HZ_RAW;
      w_waw:   w_cause = HZ_WAW;
      w_cap:   w_cause = HZ_CAP;
      default: w_cause = HZ_NONE;
    endcase
  end

  assign issue_ready = (w_cause == HZ_NONE) && !flush;
  assign w_accept    = issue_valid && issue_ready;
  assign w_push      = w_accept && !issue_long && issue_rd != '0;
  assign w_set       = w_accept && issue_long && issue_rd != '0;
  assign w_done_ok   = atomic_done_valid && atomic_done_rd != '0
                    && r_pending[atomic_done_rd];

  // WAW guarantees a same-cycle set and clear hit different rds.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending     <= '0;
      r_outstanding <= '0;
      r_err         <= 1'b0;
    end else begin
      if (w_set)
        r_pending[issue_rd] <= 1'b1;
      if (w_done_ok)
        r_pending[atomic_done_rd] <= 1'b0;
      if (w_set && !w_done_ok)
        r_outstanding <= r_outstanding + 4'd1;
      else if (!w_set && w_done_ok)
        r_outstanding <= r_outstanding - 4'd1;
      if (atomic_done_valid && !w_done_ok)
        r_err <= 1'b1;
    end
  end

  assign busy_mask   = w_busy;
  assign outstanding = r_outstanding;
  assign sb_error    = r_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed table plus randomized model check for reg_scoreboard.
module tb_reg_scoreboard;
  localparam int WB_LAT = 3;
  localparam int MAXO   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        issue_use_rs1, issue_use_rs2, issue_long;
  logic        issue_ready;
  logic        atomic_done_valid;
  logic [4:0]  atomic_done_rd;
  logic        flush;
  logic [31:0] busy_mask;
  logic [3:0]  outstanding;
  logic        sb_error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_scoreboard #(
    .WB_LAT          (WB_LAT),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .issue_valid       (issue_valid),
    .issue_rs1         (issue_rs1),
    .issue_rs2         (issue_rs2),
    .issue_use_rs1     (issue_use_rs1),
    .issue_use_rs2     (issue_use_rs2),
    .issue_rd          (issue_rd),
    .issue_long        (issue_long),
    .issue_ready       (issue_ready),
    .atomic_done_valid (atomic_done_valid),
    .atomic_done_rd    (atomic_done_rd),
    .flush             (flush),
    .busy_mask         (busy_mask),
    .outstanding       (outstanding),
    .sb_error          (sb_error)
  );

  typedef struct {
    logic        rst, v;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic [4:0]  rd;
    logic        lg, dv;
    logic [4:0]  drd;
    logic        fl;
    logic        e_rdy;
    logic [31:0] e_bm;
    logic [3:0]  e_out;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic rst, logic v, logic [4:0] rs1, logic u1,
    logic [4:0] rs2, logic u2, logic [4:0] rd, logic lg,
    logic dv, logic [4:0] drd, logic fl,
    logic e_rdy, logic [31:0] e_bm, logic [3:0] e_out, logic e_err);
    vec_t t;
    t.rst = rst; t.v = v; t.rs1 = rs1; t.u1 = u1;
    t.rs2 = rs2; t.u2 = u2; t.rd = rd; t.lg = lg;
    t.dv = dv; t.drd = drd; t.fl = fl;
    t.e_rdy = e_rdy; t.e_bm = e_bm; t.e_out = e_out; t.e_err = e_err;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(vec_t t);
    reset             = t.rst;
    issue_valid       = t.v;
    issue_rs1         = t.rs1;
    issue_use_rs1     = t.u1;
    issue_rs2         = t.rs2;
    issue_use_rs2     = t.u2;
    issue_rd          = t.rd;
    issue_long        = t.lg;
    atomic_done_valid = t.dv;
    atomic_done_rd    = t.drd;
    flush             = t.fl;
  endtask

  // Reference model: set of pending atomics, remaining pipe lifetime per rd.
  bit [31:0] mp;
  int        ttl[32];
  bit        merr;

  function automatic bit m_busy(logic [4:0] r);
    return r != 0 && (mp[r] || ttl[r] > 0);
  endfunction

  function automatic bit m_ready(vec_t t);
    bit raw, waw, cap;
    raw = (t.u1 && m_busy(t.rs1)) || (t.u2 && m_busy(t.rs2));
    waw = m_busy(t.rd);
    cap = t.lg && $countones(mp) == MAXO;
    return !raw && !waw && !cap && !t.fl;
  endfunction

  function automatic logic [31:0] m_mask();
    logic [31:0] m = '0;
    for (int r = 1; r < 32; r++)
      m[r] = m_busy(5'(r));
    return m;
  endfunction

  task automatic m_step(vec_t t);
    bit acc;
    if (t.rst) begin
      mp = '0; merr = 0;
      for (int r = 0; r < 32; r++) ttl[r] = 0;
      return;
    end
    acc = t.v && m_ready(t);
    for (int r = 0; r < 32; r++)
      if (ttl[r] > 0) ttl[r]--;
    if (t.fl)
      for (int r = 0; r < 32; r++) ttl[r] = 0;
    else if (acc && !t.lg && t.rd != 0)
      ttl[t.rd] = WB_LAT;
    if (t.dv && t.drd != 0 && mp[t.drd]) mp[t.drd] = 0;
    else if (t.dv) merr = 1;
    if (acc && t.lg && t.rd != 0) mp[t.rd] = 1;
  endtask

  initial begin
    vec_t t;
    //        rst v rs1 u1 rs2 u2 rd lg dv drd fl  rdy bm        out err
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 0, 0,0, 1,32'h0,     0,0));
    tbl.push_back(mk(0,1, 0,0, 0,0, 5,0, 0, 0,0, 1,32'h0,     0,0));
    tbl.push_back(mk(0,1, 5,1, 0,0, 0,0, 0, 0,0, 0,32'h20,    0,0));
    tbl.push_back(mk(0,1, 5,1, 0,0, 0,0, 0, 0,0, 0,32'h20,    0,0));
    tbl.push_back(mk(0,1, 5,1, 0,0, 0,0, 0, 0,0, 0,32'h20,    0,0));
    tbl.push_back(mk(0,1, 5,1, 0,0, 0,0, 0, 0,0, 1,32'h0,     0,0));
    tbl.push_back(mk(0,1, 0,0, 0,0, 7,1, 0, 0,0, 1,32'h0,     0,0));
    tbl.push_back(mk(0,1, 0,0, 7,1, 0,0, 0, 0,0, 0,32'h80,    1,0));
    tbl.push_back(mk(0,1, 0,0, 7,1, 0,0, 1, 7,0, 0,32'h80,    1,0));
    tbl.push_back(mk(0,1, 0,0, 7,1, 0,0, 0, 0,0, 1,32'h0,     0,0));
    tbl.push_back(mk(0,1, 0,0, 0,0, 1,1, 0, 0,0, 1,32'h0,     0,0));
    tbl.push_back(mk(0,1, 0,0, 0,0, 2,1, 0, 0,0, 1,32'h2,     1,0));
    tbl.push_back(mk(0,1, 0,0, 0,0, 3,1, 0, 0,0, 1,32'h6,     2,0));
    tbl.push_back(mk(0,1, 0,0, 0,0, 4,1, 0, 0,0, 1,32'he,     3,0));
    tbl.push_back(mk(0,1, 0,0, 0,0, 9,1, 1, 2,0, 0,32'h1e,    4,0));
    tbl.push_back(mk(0,1, 0,0, 0,0, 9,1, 0, 0,0, 1,32'h1a,    3,0));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 1, 1,0, 1,32'h21a,   4,0));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 1, 3,0, 1,32'h218,   3,0));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 1, 4,0, 1,32'h210,   2,0));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 1, 9,0, 1,32'h200,   1,0));
    tbl.push_back(mk(0,1, 0,0, 0,0, 6,0, 0, 0,0, 1,32'h0,     0,0));
    tbl.push_back(mk(0,1, 6,1, 0,0, 0,0, 0, 0,1, 0,32'h40,    0,0));
    tbl.push_back(mk(0,1, 6,1, 0,0, 0,0, 0, 0,0, 1,32'h0,     0,0));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 1,12,0, 1,32'h0,     0,0));
    tbl.push_back(mk(0,1, 0,0, 0,0, 8,1, 0, 0,0, 1,32'h0,     0,1));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 1, 8,0, 1,32'h100,   1,1));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 0, 0,0, 1,32'h0,     0,1));
    tbl.push_back(mk(1,0, 0,0, 0,0, 0,0, 0, 0,0, 1,32'h0,     0,1));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 0, 0,0, 1,32'h0,     0,0));
    tbl.push_back(mk(0,1, 0,0, 0,0, 0,1, 0, 0,0, 1,32'h0,     0,0));
    tbl.push_back(mk(0,1, 0,1, 0,0, 0,0, 0, 0,0, 1,32'h0,     0,0));
    tbl.push_back(mk(0,1, 0,0, 0,0,10,1, 0, 0,0, 1,32'h0,     0,0));
    tbl.push_back(mk(0,1, 0,0, 0,0,11,0, 0, 0,0, 1,32'h400,   1,0));
    tbl.push_back(mk(1,1, 0,0, 0,0,13,0, 0, 0,0, 1,32'hc00,   1,0));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 0, 0,0, 1,32'h0,     0,0));

    drive(mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    repeat (2) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("dir%0d_ready", i), 32'(issue_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("dir%0d_busy", i), busy_mask, tbl[i].e_bm);
      chk($sformatf("dir%0d_outst", i), 32'(outstanding), 32'(tbl[i].e_out));
      chk($sformatf("dir%0d_err", i), 32'(sb_error), 32'(tbl[i].e_err));
    end

    mp = '0; merr = 0;
    for (int r = 0; r < 32; r++) ttl[r] = 0;

    for (int c = 0; c < 3000; c++) begin
      t = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);
      t.rst = ($urandom_range(299) == 0);
      t.v   = ($urandom_range(3) != 0);
      t.rs1 = 5'($urandom_range(7));
      t.u1  = 1'($urandom_range(1));
      t.rs2 = 5'($urandom_range(7));
      t.u2  = 1'($urandom_range(1));
      t.rd  = 5'($urandom_range(7));
      t.lg  = ($urandom_range(2) == 0);
      t.fl  = ($urandom_range(15) == 0);
      if ($urandom_range(79) == 0) begin
        t.dv  = 1;
        t.drd = 5'($urandom_range(31));
      end else if (mp != 0 && $urandom_range(2) == 0) begin
        int s = $urandom_range(31);
        for (int k = 0; k < 32; k++)
          if (!t.dv && mp[(s + k) % 32]) begin
            t.dv  = 1;
            t.drd = 5'((s + k) % 32);
          end
      end
      @(negedge clk);
      drive(t);
      #1;
      chk("rnd_ready", 32'(issue_ready), 32'(m_ready(t)));
      chk("rnd_busy", busy_mask, m_mask());
      chk("rnd_outst", 32'(outstanding), 32'($countones(mp)));
      chk("rnd_err", 32'(sb_error), 32'(merr));
      m_step(t);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
